instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 169 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Streams 32-bit program words into a byte-wide instruction memory, one byte per cycle, little-endian.
// All outputs are registered; a range guard stops any write from reaching past MEM_DEPTH.
module instr_mem_loader #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic [31:0] load_base,
  input  logic        load_abort,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_ena,
  output logic        mem_wea,
  output logic [31:0] mem_addra,
  output logic [7:0]  mem_dina,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] word_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [31:0] base_r, base_s;
  logic [31:0] data_r, data_s;
  logic        last_r, last_s;
  logic [1:0]  idx_r, idx_s;
  logic [15:0] count_r, count_s;
  logic        err_r, err_s;
  logic        in_ready_r, in_ready_s;
  logic        mem_we_r, mem_we_s;
  logic [31:0] mem_addra_r, mem_addra_s;
  logic [7:0]  mem_dina_r, mem_dina_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        range_bad_s;

  // Last byte of the next word would land at or beyond MEM_DEPTH (34-bit sum so it cannot wrap)
  always_comb begin
    range_bad_s = (({2'b00, base_r} + {16'd0, count_r, 2'b00} + 34'd3) >= 34'(MEM_DEPTH));
  end

  // Next-state and next-output decode
  always_comb begin
    state_s = state_r;
    base_s  = base_r;
    data_s  = data_r;
    last_s  = last_r;
    idx_s   = idx_r;
    count_s = count_r;
    err_s   = err_r;
    if (load_abort) begin
      // Abort beats a simultaneous start, even from IDLE
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, ERROR: begin
          if (load_start) begin
            state_s = ARMED;
            base_s  = load_base & 32'hFFFF_FFFC;
            count_s = 16'd0;
            err_s   = 1'b0;
          end else begin
            state_s = state_r;
          end
        end
        ARMED: begin
          if (in_valid && range_bad_s) begin
            state_s = ERROR;
            err_s   = 1'b1;
          end else if (in_valid) begin
            state_s = WRITE;
            data_s  = in_data;
            last_s  = in_last;
            idx_s   = 2'd0;
          end else begin
            state_s = ARMED;
          end
        end
        WRITE: begin
          if (idx_r == 2'd3) begin
            idx_s   = 2'd0;
            count_s = (count_r == 16'hFFFF) ? count_r : count_r + 16'd1;
            state_s = last_r ? DONE : ARMED;
          end else begin
            idx_s = idx_r + 2'd1;
          end
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end

    in_ready_s = (state_s == ARMED);
    mem_we_s   = (state_s == WRITE);
    busy_s     = (state_s == ARMED) || (state_s == WRITE) || (state_s == ERROR);
    done_s     = (state_s == DONE);
    if (mem_we_s) begin
      mem_addra_s = base_s + {14'd0, count_s, 2'b00} + {30'd0, idx_s};
      mem_dina_s  = byte_sel(data_s, idx_s);
    end else begin
      mem_addra_s = 32'd0;
      mem_dina_s  = 8'd0;
    end
  end

  // State, session context and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      base_r      <= 32'd0;
      data_r      <= 32'd0;
      last_r      <= 1'b0;
      idx_r       <= 2'd0;
      count_r     <= 16'd0;
      err_r       <= 1'b0;
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addra_r <= 32'd0;
      mem_dina_r  <= 8'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      base_r      <= base_s;
      data_r      <= data_s;
      last_r      <= last_s;
      idx_r       <= idx_s;
      count_r     <= count_s;
      err_r       <= err_s;
      in_ready_r  <= in_ready_s;
      mem_we_r    <= mem_we_s;
      mem_addra_r <= mem_addra_s;
      mem_dina_r  <= mem_dina_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign mem_ena    = mem_we_r;
  assign mem_wea    = mem_we_r;
  assign mem_addra  = mem_addra_r;
  assign mem_dina   = mem_dina_r;
  assign load_busy  = busy_r;
  assign load_done  = done_r;
  assign load_err   = err_r;
  assign word_count = count_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader with hand-computed expectations.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_start = 1'b0;
  logic [31:0] load_base = 32'd0;
  logic        load_abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_last = 1'b0;
  logic        in_ready, mem_ena, mem_wea, load_busy, load_done, load_err;
  logic [31:0] mem_addra;
  logic [7:0]  mem_dina;
  logic [15:0] word_count;

  int checks = 0;
  int errors = 0;

  instr_mem_loader #(.MEM_DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
    .load_abort(load_abort), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_write(input string tag, input logic [31:0] addr, input logic [7:0] data);
    chk({tag, "_ena"}, {31'd0, mem_ena}, 32'd1);
    chk({tag, "_wea"}, {31'd0, mem_wea}, 32'd1);
    chk({tag, "_addr"}, mem_addra, addr);
    chk({tag, "_din"}, {24'd0, mem_dina}, {24'd0, data});
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ena"}, {31'd0, mem_ena}, 32'd0);
    chk({tag, "_wea"}, {31'd0, mem_wea}, 32'd0);
    chk({tag, "_addr"}, mem_addra, 32'd0);
    chk({tag, "_din"}, {24'd0, mem_dina}, 32'd0);
  endtask

  task automatic start(input logic [31:0] base);
    load_start = 1'b1;
    load_base  = base;
    tick();
    load_start = 1'b0;
  endtask

  logic [31:0] words [3];
  logic [7:0]  be_bytes [4];

  initial begin
    words[0] = 32'h0302_0100;
    words[1] = 32'h0706_0504;
    words[2] = 32'h0B0A_0908;
    be_bytes[0] = 8'hEF; be_bytes[1] = 8'hBE; be_bytes[2] = 8'hAD; be_bytes[3] = 8'hDE;

    // reset state
    #1 rst_n = 1'b0;
    #3;
    chk_quiet("rst");
    chk("rst_rdy", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, load_busy}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    chk("rst_cnt", {16'd0, word_count}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_rdy", {31'd0, in_ready}, 32'd0);

    // start and abort together from IDLE: abort wins
    load_start = 1'b1; load_abort = 1'b1; load_base = 32'h10;
    tick();
    load_start = 1'b0; load_abort = 1'b0;
    chk("sa_rdy", {31'd0, in_ready}, 32'd0);
    chk("sa_busy", {31'd0, load_busy}, 32'd0);
    tick();
    chk("sa_rdy2", {31'd0, in_ready}, 32'd0);

    // single word 0xDEADBEEF at base 0x10
    start(32'h10);
    chk("w1_rdy", {31'd0, in_ready}, 32'd1);
    chk("w1_busy", {31'd0, load_busy}, 32'd1);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_write("w1", 32'h10 + i, be_bytes[i]);
      tick();
    end
    chk("w1_done", {31'd0, load_done}, 32'd1);
    chk("w1_cnt", {16'd0, word_count}, 32'd1);
    chk("w1_busy_done", {31'd0, load_busy}, 32'd0);
    chk_quiet("w1_post");
    tick();
    chk("w1_done_pulse", {31'd0, load_done}, 32'd0);
    chk("w1_cnt_hold", {16'd0, word_count}, 32'd1);

    // three words back-to-back with in_valid held high
    start(32'h0);
    in_valid = 1'b1; in_data = words[0]; in_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bb%0d_rdy", k), {31'd0, in_ready}, 32'd1);
      tick();
      if (k < 2) begin
        in_data = words[k+1];
        in_last = (k == 1);
      end
      for (int i = 0; i < 4; i++) begin
        chk_write($sformatf("bb%0d_%0d", k, i), 4 * k + i, 8'(4 * k + i));
        tick();
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("bb_done", {31'd0, load_done}, 32'd1);
    chk("bb_cnt", {16'd0, word_count}, 32'd3);

    // range guard: second word at 0x400 is rejected
    tick();
    start(32'h3FC);
    in_valid = 1'b1; in_data = 32'h4433_2211; in_last = 1'b0;
    tick();
    in_data = 32'h8877_6655;
    for (int i = 0; i < 4; i++) begin
      chk_write($sformatf("rg_%0d", i), 32'h3FC + i, 8'(8'h11 * (i + 1)));
      tick();
    end
    chk("rg_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("rg_err", {31'd0, load_err}, 32'd1);
    chk("rg_busy", {31'd0, load_busy}, 32'd1);
    chk("rg_rdy_err", {31'd0, in_ready}, 32'd0);
    chk("rg_done", {31'd0, load_done}, 32'd0);
    chk("rg_cnt", {16'd0, word_count}, 32'd1);
    chk_quiet("rg_q");
    tick();
    chk("rg_hold_busy", {31'd0, load_busy}, 32'd1);
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    chk("rg_ab_busy", {31'd0, load_busy}, 32'd0);
    chk("rg_ab_err", {31'd0, load_err}, 32'd1);

    // abort during byte index 2
    start(32'h20);
    chk("ab_err_clr", {31'd0, load_err}, 32'd0);
    in_valid = 1'b1; in_data = 32'hCAFE_F00D; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_write("ab0", 32'h20, 8'h0D);
    tick();
    chk_write("ab1", 32'h21, 8'hF0);
    tick();
    chk_write("ab2", 32'h22, 8'hFE);
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    chk_quiet("ab_post");
    chk("ab_busy", {31'd0, load_busy}, 32'd0);
    chk("ab_cnt", {16'd0, word_count}, 32'd0);
    chk("ab_done", {31'd0, load_done}, 32'd0);
    tick();
    chk("ab_done2", {31'd0, load_done}, 32'd0);

    // start ignored mid-WRITE, then reset mid-WRITE
    start(32'h40);
    in_valid = 1'b1; in_data = 32'h1234_5678; in_last = 1'b1;
    tick();
    chk_write("rs0", 32'h40, 8'h78);
    load_start = 1'b1; load_base = 32'h80;
    tick();
    load_start = 1'b0;
    chk_write("rs1", 32'h41, 8'h56);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_wea", {31'd0, mem_wea}, 32'd0);
    chk_quiet("rs_async");
    chk("rs_busy", {31'd0, load_busy}, 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rs_idle_rdy%0d", i), {31'd0, in_ready}, 32'd0);
      chk($sformatf("rs_idle_ena%0d", i), {31'd0, mem_ena}, 32'd0);
      chk($sformatf("rs_idle_busy%0d", i), {31'd0, load_busy}, 32'd0);
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
